lcd_controller: RTL

Sequencer for the 4-bit character LCD driven by the MiniAlu top level. It runs the power-on initialisation of the display, then accepts one byte per handshake from the ALU datapath on the `iWrite`/`iData`/`oReady` interface. Each byte becomes two timed nibble writes on the `oLCD_*` pins. It owns all LCD timing, so the datapath only waits for `oReady`.

---
 rtl/lcd_pkg.sv | 48 ++++
 rtl/lcd_if.sv | 11 +
 rtl/lcd_nibble_writer.sv | 80 ++++++++
 rtl/lcd_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the 4-bit character LCD sequencer: FSM encodings,
// power-on init data and the fixed nibble setup time.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_POWERON,
        S_INIT_NIB,
        S_INIT_WAIT,
        S_IDLE,
        S_HI,
        S_GAP,
        S_LO,
        S_WAIT
    } lcd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_PULSE
    } nib_state_t;

    localparam int LCD_SETUP_CYCLES = 2;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Wake-up nibbles 3,3,3 then 2 to switch the panel into 4-bit mode.
    function automatic logic [3:0] lcd_init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    // Function set, entry mode, display on, clear.
    function automatic logic [7:0] lcd_init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h28;
            2'd1:    cmd = 8'h06;
            2'd2:    cmd = 8'h0C;
            default: cmd = 8'h01;
        endcase
        return cmd;
    endfunction

    function automatic int lcd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_if.sv
// Byte write handshake between the ALU datapath (master) and the LCD
// controller (slave): a write is taken on an edge where oReady and iWrite are both high.
interface lcd_if;
    logic       iWrite;
    logic [7:0] iData;
    logic       iRS;
    logic       oReady;

    modport master (output iWrite, output iData, output iRS, input oReady);
    modport slave  (input iWrite, input iData, input iRS, output oReady);
endinterface

// File: rtl/lcd_nibble_writer.sv
// One LCD nibble: data/RS out on start, E high after 2 setup cycles for P_ENABLE_CYCLES; data then held.
// Latency 2+EN cycles start-to-E-fall (done marks the last E-high cycle); start is only taken when idle.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int P_ENABLE_CYCLES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] nibble,
    input  logic       rs,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [3:0] lcd_data
);

    localparam int CW = $clog2(lcd_max(P_ENABLE_CYCLES, LCD_SETUP_CYCLES) + 1);

    nib_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          e_n, rs_n;
    logic [3:0]    data_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= W_IDLE;
            cnt      <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            lcd_e    <= e_n;
            lcd_rs   <= rs_n;
            lcd_data <= data_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        e_n     = lcd_e;
        rs_n    = lcd_rs;
        data_n  = lcd_data;
        done    = 1'b0;
        unique case (state)
            W_IDLE: begin
                if (start) begin
                    data_n  = nibble;
                    rs_n    = rs;
                    cnt_n   = CW'(LCD_SETUP_CYCLES - 1);
                    state_n = W_SETUP;
                end
            end
            W_SETUP: begin
                if (cnt == '0) begin
                    e_n     = 1'b1;
                    cnt_n   = CW'(P_ENABLE_CYCLES - 1);
                    state_n = W_PULSE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            W_PULSE: begin
                if (cnt == '0) begin
                    e_n     = 1'b0;
                    done    = 1'b1;
                    state_n = W_IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = W_IDLE;
        endcase
    end

endmodule

// File: rtl/lcd_controller.sv
// LCD sequencer: power-on wait, optional hardware init (`LCD_AUTO_INIT_EN), then one byte per handshake as two nibbles.
// Busy 2+EN+GAP+2+EN+WAIT cycles per byte; oReady is low while busy and writes are then ignored, not queued.
module lcd_controller
    import lcd_pkg::*;
#(
    parameter int P_POWERON_CYCLES = 750000,
    parameter int P_ENABLE_CYCLES  = 12,
    parameter int P_NIBBLE_GAP     = 50,
    parameter int P_CMD_WAIT       = 2000,
    parameter int P_CLEAR_WAIT     = 82000,
    parameter int P_INIT_WAIT1     = 205000,
    parameter int P_INIT_WAIT2     = 5000
) (
    input  logic       Clock,
    input  logic       Reset,
    lcd_if.slave       host,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_StrataFlashControl,
    output logic [3:0] oLCD_Data
);

    localparam int CNT_MAX = lcd_max(lcd_max(lcd_max(P_POWERON_CYCLES, P_CLEAR_WAIT),
                                             lcd_max(P_INIT_WAIT1, P_INIT_WAIT2)),
                                     lcd_max(P_CMD_WAIT, P_NIBBLE_GAP));
    localparam int CW = $clog2(CNT_MAX + 1);

    lcd_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n, settle;
    logic [7:0]    byte_q, byte_n;
    logic          rs_q, rs_n, ready_q, ready_n;
    logic          wr_start, wr_rs, wr_done;
    logic [3:0]    wr_nib;
`ifdef LCD_AUTO_INIT_EN
    logic [1:0]    idx, idx_n;
    logic          in_init, in_init_n;
    logic [CW-1:0] init_wait;

    assign init_wait = (idx == 2'd0) ? CW'(P_INIT_WAIT1 - 1) :
                       (idx == 2'd1) ? CW'(P_INIT_WAIT2 - 1) : CW'(P_CMD_WAIT - 1);
`endif

    assign settle = (!rs_q && (byte_q == LCD_CMD_CLEAR || byte_q == LCD_CMD_HOME)) ?
                    CW'(P_CLEAR_WAIT - 1) : CW'(P_CMD_WAIT - 1);

    assign host.oReady             = ready_q;
    assign oLCD_ReadWrite          = 1'b0;
    assign oLCD_StrataFlashControl = 1'b1;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_POWERON;
            cnt     <= CW'(P_POWERON_CYCLES);
            byte_q  <= '0;
            rs_q    <= 1'b0;
            ready_q <= 1'b0;
`ifdef LCD_AUTO_INIT_EN
            idx     <= '0;
            in_init <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            byte_q  <= byte_n;
            rs_q    <= rs_n;
            ready_q <= ready_n;
`ifdef LCD_AUTO_INIT_EN
            idx     <= idx_n;
            in_init <= in_init_n;
`endif
        end
    end

    // The writer is started on the edge that enters S_HI, S_LO or S_INIT_NIB.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        byte_n   = byte_q;
        rs_n     = rs_q;
        ready_n  = 1'b0;
        wr_start = 1'b0;
        wr_nib   = byte_q[7:4];
        wr_rs    = rs_q;
`ifdef LCD_AUTO_INIT_EN
        idx_n     = idx;
        in_init_n = in_init;
`endif
        unique case (state)
            S_POWERON: begin
                if (cnt == '0) begin
`ifdef LCD_AUTO_INIT_EN
                    idx_n    = 2'd0;
                    wr_start = 1'b1;
                    wr_nib   = lcd_init_nibble(2'd0);
                    wr_rs    = 1'b0;
                    state_n  = S_INIT_NIB;
`else
                    ready_n  = 1'b1;
                    state_n  = S_IDLE;
`endif
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
`ifdef LCD_AUTO_INIT_EN
            S_INIT_NIB: begin
                if (wr_done) begin
                    cnt_n   = init_wait;
                    state_n = S_INIT_WAIT;
                end
            end
            S_INIT_WAIT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (idx != 2'd3) begin
                    idx_n    = idx + 2'd1;
                    wr_start = 1'b1;
                    wr_nib   = lcd_init_nibble(idx_n);
                    wr_rs    = 1'b0;
                    state_n  = S_INIT_NIB;
                end else begin
                    idx_n     = 2'd0;
                    in_init_n = 1'b1;
                    byte_n    = lcd_init_cmd(2'd0);
                    rs_n      = 1'b0;
                    wr_start  = 1'b1;
                    wr_nib    = byte_n[7:4];
                    wr_rs     = 1'b0;
                    state_n   = S_HI;
                end
            end
`endif
            S_IDLE: begin
                ready_n = 1'b1;
                if (host.iWrite) begin
                    byte_n   = host.iData;
                    rs_n     = host.iRS;
                    wr_start = 1'b1;
                    wr_nib   = host.iData[7:4];
                    wr_rs    = host.iRS;
                    ready_n  = 1'b0;
                    state_n  = S_HI;
                end
            end
            S_HI: begin
                if (wr_done) begin
                    cnt_n   = CW'(P_NIBBLE_GAP - 1);
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    wr_start = 1'b1;
                    wr_nib   = byte_q[3:0];
                    state_n  = S_LO;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            S_LO: begin
                if (wr_done) begin
                    cnt_n   = settle;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    ready_n = 1'b1;
                    state_n = S_IDLE;
`ifdef LCD_AUTO_INIT_EN
                    if (in_init) begin
                        if (idx == 2'd3) begin
                            in_init_n = 1'b0;
                        end else begin
                            idx_n    = idx + 2'd1;
                            byte_n   = lcd_init_cmd(idx_n);
                            rs_n     = 1'b0;
                            wr_start = 1'b1;
                            wr_nib   = byte_n[7:4];
                            wr_rs    = 1'b0;
                            ready_n  = 1'b0;
                            state_n  = S_HI;
                        end
                    end
`endif
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = S_POWERON;
        endcase
    end

    lcd_nibble_writer #(
        .P_ENABLE_CYCLES(P_ENABLE_CYCLES)
    ) u_nibble_writer (
        .clk      (Clock),
        .rst      (Reset),
        .start    (wr_start),
        .nibble   (wr_nib),
        .rs       (wr_rs),
        .done     (wr_done),
        .lcd_e    (oLCD_Enabled),
        .lcd_rs   (oLCD_RegisterSelect),
        .lcd_data (oLCD_Data)
    );

endmodule
